// File: rtl/pio_bus_bridge_pkg.sv
// Shared types and elaboration-time helpers for the parallel-I/O bus bridge.
package pio_bridge_pkg;

    typedef enum logic [2:0] {
        ST_PWRST,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } PioState_t;

    // One phase counter serves every timed phase, so it must hold the largest reload value.
    function automatic int phaseCntWidth(input int setupCyc, input int strobeCyc,
                                         input int recoveryCyc, input int pwrstCyc);
        int m;
        m = setupCyc;
        if (strobeCyc > m) m = strobeCyc;
        if (recoveryCyc > m) m = recoveryCyc;
        if (pwrstCyc > m) m = pwrstCyc;
        return $clog2(m + 1);
    endfunction

    function automatic int beatCount(input int busDw, input int ioDw);
        return busDw / ioDw;
    endfunction

    function automatic bit paramsLegal(input int busDw, input int ioDw,
                                       input int strobeCyc, input int pwrstCyc);
        return (ioDw > 0) && (busDw % ioDw == 0) && (strobeCyc >= 1) && (pwrstCyc >= 1);
    endfunction

endpackage

// File: rtl/pio_bus_bridge_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            q_o    <= '0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pio_bus_bridge.sv
// Bridge from the internal request/response bus to a CS/IOR/IOW/CMD parallel-I/O
// device, with device power-on reset sequencing and interrupt synchronisation.
module pio_bus_bridge
    import pio_bridge_pkg::*;
#(
    parameter int BUS_DW           = 32,
    parameter int IO_DW            = 16,
    parameter int SETUP_CYC        = 1,
    parameter int STROBE_CYC       = 2,
    parameter int RECOVERY_CYC     = 5,
    parameter int PWRST_CYC        = 64,
    parameter bit INTR_ACTIVE_HIGH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_cmd,
    input  logic              req_wide,
    input  logic [BUS_DW-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [BUS_DW-1:0] rsp_rdata,
    output logic              irq,
    output logic              io_pwrst_n,
    output logic              io_cs_n,
    output logic              io_ior_n,
    output logic              io_iow_n,
    output logic              io_cmd,
    output logic [IO_DW-1:0]  io_sd_o,
    output logic              io_sd_oe,
    input  logic [IO_DW-1:0]  io_sd_i,
    input  logic              io_intr
);

    localparam int BEATS  = beatCount(BUS_DW, IO_DW);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W  = phaseCntWidth(SETUP_CYC, STROBE_CYC, RECOVERY_CYC, PWRST_CYC);

    if (!paramsLegal(BUS_DW, IO_DW, STROBE_CYC, PWRST_CYC)) begin : gIllegalParams
        $error("pio_bus_bridge: BUS_DW must be a multiple of IO_DW, STROBE_CYC and PWRST_CYC >= 1");
    end

    PioState_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              write_q, write_d;
    logic              cmd_q, cmd_d;
    logic              wide_q, wide_d;
    logic [BUS_DW-1:0] wdata_q, wdata_d;
    logic [BUS_DW-1:0] rdata_q, rdata_d;
    logic              rspValid_q, rspValid_d;

    logic              lastBeat;
    logic              beatDone;
    logic              startBeat;
    logic              activePhase;
    logic [IO_DW-1:0]  wrSlice;
    logic              intrAsserted;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rdata_q;
    assign lastBeat  = !wide_q || (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        write_d    = write_q;
        cmd_d      = cmd_q;
        wide_d     = wide_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rspValid_d = 1'b0;
        beatDone   = 1'b0;
        startBeat  = 1'b0;

        case (state_q)
            ST_PWRST: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_IDLE: begin
                if (req_valid) begin
                    write_d   = req_write;
                    cmd_d     = req_cmd;
                    wide_d    = req_wide;
                    wdata_d   = req_wdata;
                    rdata_d   = '0;
                    beat_d    = '0;
                    startBeat = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = CNT_W'(STROBE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) state_d = ST_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_HOLD: begin
                // The pins lag the state by one cycle, so this edge ends the pin strobe.
                if (!write_q) rdata_d[beat_q*IO_DW +: IO_DW] = io_sd_i;
                if (RECOVERY_CYC == 0) begin
                    beatDone = 1'b1;
                end else begin
                    state_d = ST_RECOVER;
                    cnt_d   = CNT_W'(RECOVERY_CYC - 1);
                end
            end
            ST_RECOVER: begin
                if (cnt_q == '0) beatDone = 1'b1;
                else             cnt_d    = cnt_q - 1'b1;
            end
            default: state_d = ST_PWRST;
        endcase

        if (beatDone) begin
            if (lastBeat) begin
                state_d    = ST_IDLE;
                rspValid_d = 1'b1;
            end else begin
                beat_d    = beat_q + 1'b1;
                startBeat = 1'b1;
            end
        end

        if (startBeat) begin
            if (SETUP_CYC == 0) begin
                state_d = ST_STROBE;
                cnt_d   = CNT_W'(STROBE_CYC - 1);
            end else begin
                state_d = ST_SETUP;
                cnt_d   = CNT_W'(SETUP_CYC - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_PWRST;
            cnt_q      <= CNT_W'(PWRST_CYC - 1);
            beat_q     <= '0;
            write_q    <= 1'b0;
            cmd_q      <= 1'b0;
            wide_q     <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rspValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            write_q    <= write_d;
            cmd_q      <= cmd_d;
            wide_q     <= wide_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rspValid_q <= rspValid_d;
        end
    end

    assign activePhase = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
    assign wrSlice     = wdata_q[beat_q*IO_DW +: IO_DW];

    // Device pins are registered from the current phase; read data never reaches io_sd_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_pwrst_n <= 1'b0;
            io_cs_n    <= 1'b1;
            io_ior_n   <= 1'b1;
            io_iow_n   <= 1'b1;
            io_cmd     <= 1'b0;
            io_sd_o    <= '0;
            io_sd_oe   <= 1'b0;
        end else begin
            io_pwrst_n <= (state_d != ST_PWRST);
            io_cs_n    <= !activePhase;
            io_ior_n   <= !((state_q == ST_STROBE) && !write_q);
            io_iow_n   <= !((state_q == ST_STROBE) && write_q);
            io_sd_oe   <= activePhase && write_q;
            if (activePhase) io_cmd <= cmd_q;
            if (activePhase && write_q) io_sd_o <= wrSlice;
        end
    end

    assign intrAsserted = INTR_ACTIVE_HIGH ? io_intr : !io_intr;

    sync_2ff #(
        .WIDTH(1)
    ) u_intrSync (
        .clk(clk),
        .rst(rst),
        .d_i(intrAsserted),
        .q_o(irq)
    );

endmodule

// File: tb/tb_pio_bus_bridge.sv
// Directed self-checking bench for pio_bus_bridge, with a second instance using
// an active-low interrupt input.
module tb_pio_bus_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_write, req_cmd, req_wide;
    logic [31:0] req_wdata;
    logic [15:0] io_sd_i;
    logic        io_intr;

    logic        req_ready, rsp_valid, irq, io_pwrst_n, io_cs_n, io_ior_n, io_iow_n, io_cmd, io_sd_oe;
    logic [31:0] rsp_rdata;
    logic [15:0] io_sd_o;

    logic        lReqReady, lRspValid, lIrq, lPwrstN, lCsN, lIorN, lIowN, lCmd, lSdOe;
    logic [31:0] lRspRdata;
    logic [15:0] lSdO;

    int          cmpCount = 0;
    int          errCount = 0;

    logic [39:0] csLow, iorLow, iowLow, oeHigh, cmdHigh, rspSeen;
    logic [15:0] sdoTrace [40];
    logic [31:0] rdataAtRsp;
    logic [15:0] devData [2];

    always #5 clk = ~clk;

    pio_bus_bridge dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_cmd(req_cmd), .req_wide(req_wide), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .irq(irq),
        .io_pwrst_n(io_pwrst_n), .io_cs_n(io_cs_n), .io_ior_n(io_ior_n), .io_iow_n(io_iow_n),
        .io_cmd(io_cmd), .io_sd_o(io_sd_o), .io_sd_oe(io_sd_oe), .io_sd_i(io_sd_i),
        .io_intr(io_intr)
    );

    pio_bus_bridge #(.INTR_ACTIVE_HIGH(1'b0)) dutLow (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(lReqReady), .req_write(req_write),
        .req_cmd(req_cmd), .req_wide(req_wide), .req_wdata(req_wdata),
        .rsp_valid(lRspValid), .rsp_rdata(lRspRdata), .irq(lIrq),
        .io_pwrst_n(lPwrstN), .io_cs_n(lCsN), .io_ior_n(lIorN), .io_iow_n(lIowN),
        .io_cmd(lCmd), .io_sd_o(lSdO), .io_sd_oe(lSdOe), .io_sd_i(io_sd_i),
        .io_intr(io_intr)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        cmpCount++;
        assert (observed === expected) else begin
            errCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Waits for the bridge to be ready, presents one request and returns at the
    // falling edge after the accept edge (cycle 0 of the access).
    task automatic applyStimulus(input logic wr, input logic cmd, input logic wide,
                                 input logic [31:0] wd, input bit holdValid);
        int waitCyc = 0;
        while (req_ready !== 1'b1 && waitCyc < 300) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("readyBeforeRequest", 64'(req_ready), 64'h1);
        req_write = wr;
        req_cmd   = cmd;
        req_wide  = wide;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!holdValid) req_valid = 1'b0;
    endtask

    // Records pin activity for n cycles, answering reads from devData and
    // dropping a held request once it has been accepted.
    task automatic captureTrace(input int n);
        int  devIdx = 0;
        logic prevIor = 1'b1;
        bit  acceptPending = 1'b0;
        csLow = '0; iorLow = '0; iowLow = '0; oeHigh = '0; cmdHigh = '0; rspSeen = '0;
        rdataAtRsp = '0;
        for (int c = 0; c < n; c++) begin
            if (acceptPending) begin
                req_valid     = 1'b0;
                acceptPending = 1'b0;
            end
            csLow[c]   = !io_cs_n;
            iorLow[c]  = !io_ior_n;
            iowLow[c]  = !io_iow_n;
            oeHigh[c]  = io_sd_oe;
            cmdHigh[c] = io_cmd;
            rspSeen[c] = rsp_valid;
            sdoTrace[c] = io_sd_o;
            if (io_ior_n && !prevIor && devIdx < 1) devIdx++;
            prevIor = io_ior_n;
            if (!io_ior_n) io_sd_i = devData[devIdx];
            if (rsp_valid) rdataAtRsp = rsp_rdata;
            if (req_valid && req_ready) acceptPending = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic countPwrst(output int count, output logic badCtl, output logic rspHit);
        count  = 0;
        badCtl = 1'b0;
        rspHit = 1'b0;
        while (io_pwrst_n === 1'b0 && count < 200) begin
            count++;
            if (io_cs_n !== 1'b1 || io_ior_n !== 1'b1 || io_iow_n !== 1'b1 ||
                io_sd_oe !== 1'b0 || req_ready !== 1'b0) badCtl = 1'b1;
            if (rsp_valid !== 1'b0) rspHit = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic irqSequence();
        io_intr = 1'b0;
        @(negedge clk);
        checkOutput("irqLowFirstFlopOnly", 64'(lIrq), 64'h0);
        @(negedge clk);
        checkOutput("irqHighIdle", 64'(irq), 64'h0);
        checkOutput("irqLowIdle", 64'(lIrq), 64'h1);
        io_intr = 1'b1;
        @(negedge clk);
        checkOutput("irqHighDelay1", 64'(irq), 64'h0);
        checkOutput("irqLowDelay1", 64'(lIrq), 64'h1);
        @(negedge clk);
        checkOutput("irqHighDelay2", 64'(irq), 64'h1);
        checkOutput("irqLowDelay2", 64'(lIrq), 64'h0);
        io_intr = 1'b0;
        @(negedge clk);
        checkOutput("irqHighFallDelay1", 64'(irq), 64'h1);
        @(negedge clk);
        checkOutput("irqHighFallDelay2", 64'(irq), 64'h0);
        checkOutput("irqLowFallDelay2", 64'(lIrq), 64'h1);
        checkOutput("irqDuringPwrst", 64'(io_pwrst_n), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   pwCount;
        logic pwBad, pwRsp;

        req_valid = 1'b0; req_write = 1'b0; req_cmd = 1'b0; req_wide = 1'b0;
        req_wdata = '0; io_sd_i = '0; io_intr = 1'b0;
        devData[0] = 16'h0000; devData[1] = 16'h0000;

        repeat (3) @(negedge clk);
        checkOutput("rstPwrstN", 64'(io_pwrst_n), 64'h0);
        checkOutput("rstCsN", 64'(io_cs_n), 64'h1);
        checkOutput("rstIorN", 64'(io_ior_n), 64'h1);
        checkOutput("rstIowN", 64'(io_iow_n), 64'h1);
        checkOutput("rstSdOe", 64'(io_sd_oe), 64'h0);
        checkOutput("rstSdO", 64'(io_sd_o), 64'h0);
        checkOutput("rstCmd", 64'(io_cmd), 64'h0);
        checkOutput("rstReqReady", 64'(req_ready), 64'h0);
        checkOutput("rstRspValid", 64'(rsp_valid), 64'h0);
        checkOutput("rstRspRdata", 64'(rsp_rdata), 64'h0);
        checkOutput("rstIrq", 64'(irq), 64'h0);
        checkOutput("rstLowVariantPins",
                    64'({lPwrstN, lCsN, lIorN, lIowN, lSdOe, lCmd, lReqReady, lRspValid, lIrq}),
                    64'b0_1_1_1_0_0_0_0_0);
        checkOutput("rstLowVariantData", 64'({lRspRdata, lSdO}), 64'h0);

        rst = 1'b0;
        countPwrst(pwCount, pwBad, pwRsp);
        checkOutput("pwrstLength", 64'(pwCount), 64'd64);
        checkOutput("pwrstControlsIdle", 64'(pwBad), 64'h0);
        checkOutput("readyAfterPwrst", 64'(req_ready), 64'h1);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_00A5, 1'b0);
        captureTrace(12);
        checkOutput("wrCsLow", 64'(csLow), 64'h01E);
        checkOutput("wrIowLow", 64'(iowLow), 64'h00C);
        checkOutput("wrIorLow", 64'(iorLow), 64'h000);
        checkOutput("wrOeHigh", 64'(oeHigh), 64'h01E);
        checkOutput("wrCmdHigh", 64'(cmdHigh), 64'h000);
        checkOutput("wrRspValid", 64'(rspSeen), 64'h200);
        checkOutput("wrSdOSetup", 64'(sdoTrace[1]), 64'h00A5);
        checkOutput("wrSdOHold", 64'(sdoTrace[4]), 64'h00A5);

        devData[0] = 16'h1234;
        devData[1] = 16'hABCD;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
        captureTrace(20);
        checkOutput("rdWideIorLow", 64'(iorLow), 64'h0180C);
        checkOutput("rdWideCsLow", 64'(csLow), 64'h03C1E);
        checkOutput("rdWideOeNever", 64'(oeHigh), 64'h0);
        checkOutput("rdWideIowNever", 64'(iowLow), 64'h0);
        checkOutput("rdWideCmdHigh", 64'(cmdHigh), 64'hFFFFE);
        checkOutput("rdWideRspValid", 64'(rspSeen), 64'h40000);
        checkOutput("rdWideRdata", 64'(rdataAtRsp), 64'hABCD_1234);

        devData[0] = 16'h0000;
        devData[1] = 16'h0000;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0011, 1'b1);
        req_write = 1'b1;
        req_cmd   = 1'b1;
        req_wide  = 1'b1;
        req_wdata = 32'hBEEF_CAFE;
        captureTrace(30);
        checkOutput("b2bIowLow", 64'(iowLow), 64'h0060_300C);
        checkOutput("b2bCsLow", 64'(csLow), 64'h00F0_781E);
        checkOutput("b2bOeHigh", 64'(oeHigh), 64'h00F0_781E);
        checkOutput("b2bRspValid", 64'(rspSeen), 64'h1000_0200);
        checkOutput("b2bFirstSdO", 64'(sdoTrace[2]), 64'h0011);
        checkOutput("b2bBeat0SdO", 64'(sdoTrace[12]), 64'hCAFE);
        checkOutput("b2bBeat1SdO", 64'(sdoTrace[21]), 64'hBEEF);
        checkOutput("b2bValidDropped", 64'(req_valid), 64'h0);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0077, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("midStrobeIowLow", 64'(io_iow_n), 64'h0);
        rst = 1'b1;
        #1;
        checkOutput("midRstIowN", 64'(io_iow_n), 64'h1);
        checkOutput("midRstCsN", 64'(io_cs_n), 64'h1);
        checkOutput("midRstSdOe", 64'(io_sd_oe), 64'h0);
        checkOutput("midRstPwrstN", 64'(io_pwrst_n), 64'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("midRstRspValid", 64'(rsp_valid), 64'h0);
        rst = 1'b0;
        fork
            countPwrst(pwCount, pwBad, pwRsp);
            irqSequence();
        join
        checkOutput("rerunPwrstLength", 64'(pwCount), 64'd64);
        checkOutput("rerunPwrstControlsIdle", 64'(pwBad), 64'h0);
        checkOutput("rerunNoRspValid", 64'(pwRsp), 64'h0);
        checkOutput("rerunReadyAfterPwrst", 64'(req_ready), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule

// File: doc/pio_bus_bridge.md
Name: pio_bus_bridge

Overview:
Parametrised bridge from the internal single-master request/response bus to an external asynchronous parallel-I/O device. The target is a DM9000-class Ethernet MAC or any CS/IOR/IOW/CMD device. It generalises data width, beat count and per-phase timing (setup/strobe/hold/recovery), and splits wide accesses into multiple device beats. It also owns device power-on reset sequencing and interrupt synchronisation, and sits between the data bus decoder and the board pins.

Parameters:
BUS_DW, 32, internal bus data width; must be a multiple of IO_DW
IO_DW, 16, device data-bus width
SETUP_CYC, 1, cycles cs_n low before strobe; 0 allowed (phase skipped)
STROBE_CYC, 2, cycles ior_n/iow_n held low; must be ≥1
RECOVERY_CYC, 5, idle cycles after each beat, all controls high
PWRST_CYC, 64, cycles io_pwrst_n held low after reset release; must be ≥1
INTR_ACTIVE_HIGH, 1, polarity of io_intr

Ports:
clk  in  1  bridge clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  bridge can accept; accept = req_valid & req_ready
req_write  in  1  1 = write, 0 = read
req_cmd  in  1  driven to io_cmd (1 = data port, 0 = index port)
req_wide  in  1  1 = BUS_DW/IO_DW beats, 0 = single beat
req_wdata  in  BUS_DW  write data, beat k uses bits [k*IO_DW +: IO_DW]
rsp_valid  out  1  one-cycle pulse, access complete
rsp_rdata  out  BUS_DW  read data, valid with rsp_valid
irq  out  1  synchronised active-high interrupt
io_pwrst_n  out  1  device reset
io_cs_n, io_ior_n, io_iow_n  out  1 each  device strobes, active-low
io_cmd  out  1  device command/data select
io_sd_o  out  IO_DW  write data
io_sd_oe  out  1  tri-state enable for io_sd_o
io_sd_i  in  IO_DW  device read data
io_intr  in  1  raw device interrupt

Behaviour:
- States: PWRST, IDLE, SETUP, STROBE, HOLD, RECOVER. One down-counter, width clog2 of the max of the cycle parameters plus 1. One beat index register.
- Reset values: state PWRST, io_pwrst_n=0, io_cs_n/ior_n/iow_n=1, io_sd_oe=0, io_sd_o=0, io_cmd=0, req_ready=0, rsp_valid=0, rsp_rdata=0, irq=0.
- All io_* outputs are registered, with no combinational path from inputs.
- PWRST: hold io_pwrst_n=0 for PWRST_CYC cycles after rst falls, then io_pwrst_n=1 → IDLE.
- IDLE: req_ready=1. On accept, latch write/cmd/wide/wdata, set beat=0, go to SETUP (or STROBE if SETUP_CYC=0).
- SETUP: cs_n=0, io_cmd latched; for writes, oe=1 and sd_o = current beat slice. Lasts SETUP_CYC cycles.
- STROBE: as SETUP plus ior_n=0 (read) or iow_n=0 (write) for exactly STROBE_CYC cycles. For reads, io_sd_i is captured into slice [beat] on the edge ending the last STROBE cycle.
- HOLD: one cycle; cs_n=0, strobes high, write data and oe still driven.
- RECOVER: all controls high, oe=0, for RECOVERY_CYC cycles. Then:
  - if more beats remain: beat+1 → SETUP/STROBE;
  - otherwise: → IDLE with rsp_valid=1 in that first IDLE cycle.
- A new request may be accepted in the same cycle rsp_valid is high.
- Per-beat latency L = SETUP_CYC + STROBE_CYC + 1 + RECOVERY_CYC. rsp_valid occurs beats×L cycles after the accept edge (defaults: 9 narrow, 18 wide).
- Narrow read: rsp_rdata zero-extended. Wide: beat 0 is the least significant slice; all beats use the same io_cmd. Unused rdata slices are zeroed at accept.
- req_* inputs are ignored outside accept. No request is dropped; the requester holds req_valid until accepted.
- irq: 2-flop synchroniser of io_intr, inverted when INTR_ACTIVE_HIGH=0. irq is independent of the FSM and runs during PWRST.
- rst asserted mid-access: strobes high and oe=0 immediately (async), no rsp_valid, PWRST sequence reruns.
- Read data is never driven onto io_sd_o. io_sd_oe=0 at every point in a read.

Decomposition:
- Package pio_bridge_pkg: state enum PioState_t, phase-counter width function, beat-count constant derivation (BUS_DW/IO_DW), and parameter legality checks (elaboration assertions: BUS_DW % IO_DW == 0, STROBE_CYC ≥ 1).
- Sub-module sync_2ff (parametrised width) for io_intr. The FSM and datapath stay in pio_bus_bridge.

Test Plan:
- Reset release → io_pwrst_n low exactly 64 cycles, then req_ready=1; strobes high, oe=0 throughout.
- Narrow write, cmd=0, wdata=0x0000_00A5 → cs_n low 4 cycles, iow_n low cycles 2–3 after accept, sd_o=0x00A5 with oe high 4 cycles, io_cmd=0, rsp_valid at cycle 9.
- Wide read, cmd=1, device returns 0x1234 then 0xABCD → two ior_n pulses 9 cycles apart, rsp_rdata=0xABCD_1234 at cycle 18, oe never high.
- Back-to-back: second request held valid during rsp_valid → accepted that cycle; no gap beyond RECOVERY_CYC between beats.
- rst pulse during STROBE of a write → iow_n/cs_n high and oe low within the reset, no rsp_valid, full PWRST sequence repeats.
- io_intr pulse, INTR_ACTIVE_HIGH=0 variant → irq follows inverted io_intr with 2-cycle delay, including during PWRST.
